p1_byte_packer: RTL and testbench

P1_BYTE_PACKER -- requirements
Module: p1_byte_packer

---
 rtl/p1_byte_packer.sv | 81 ++++++++
 tb/tb_p1_byte_packer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/p1_byte_packer.sv
// p1_byte_packer
// Packs a serial byte stream (most significant byte first) into 32-bit
// words. Three bytes are held in a partial word; the fourth byte is merged
// with them directly into a single-entry output buffer, so a full word
// appears one clock after its last byte.
//
// Ports:
//   clk       - clock, all state updates on the rising edge
//   reset     - asynchronous, active-high reset
//   clear     - synchronous discard of the partial word (output buffer kept)
//   in_valid  - in_data holds a byte
//   in_data   - input byte
//   in_ready  - a byte can be accepted this cycle (combinational)
//   out_valid - out_word holds a complete word
//   out_word  - assembled word, first byte in bits [31:24]
//   out_ready - downstream takes out_word this cycle
//   byte_cnt  - number of bytes held in the partial word (0-3)
module p1_byte_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        out_valid,
  output logic [31:0] out_word,
  input  logic        out_ready,
  output logic [1:0]  byte_cnt
);

  // Only three bytes are ever stored here; the fourth goes straight into
  // out_word together with these, which is what keeps the latency at 1.
  logic [23:0] partial_word;
  logic        accept;
  logic        word_done;
  logic        out_taken;

  // The only case that must stall is a fourth byte arriving while the
  // output buffer is full and not being drained on this same edge.
  assign in_ready  = (byte_cnt != 2'd3) || !out_valid || out_ready;
  assign accept    = in_valid && in_ready && !clear;
  assign word_done = accept && (byte_cnt == 2'd3);
  assign out_taken = out_valid && out_ready;

  // Partial-word assembly. Clear takes priority over an arriving byte.
  // Stale lane contents after a completed word need no wiping, since each
  // lane is rewritten before the next word reads it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_cnt     <= 2'd0;
      partial_word <= 24'h000000;
    end else if (clear) begin
      byte_cnt     <= 2'd0;
      partial_word <= 24'h000000;
    end else if (accept) begin
      byte_cnt <= byte_cnt + 2'd1;
      case (byte_cnt)
        2'd0:    partial_word[23:16] <= in_data;
        2'd1:    partial_word[15:8]  <= in_data;
        2'd2:    partial_word[7:0]   <= in_data;
        default: partial_word        <= partial_word;
      endcase
    end
  end

  // Output buffer. Loading a new word wins over the handshake, so a
  // word completing on the same edge the old one leaves keeps out_valid
  // high without a bubble. Clear never touches this buffer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_word  <= 32'h00000000;
      out_valid <= 1'b0;
    end else if (word_done) begin
      out_word  <= {partial_word, in_data};
      out_valid <= 1'b1;
    end else if (out_taken) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_p1_byte_packer.sv
// tb_p1_byte_packer
// Self-checking bench for p1_byte_packer. A behavioural model (byte queue
// plus a one-entry output buffer) predicts every cycle; directed tests also
// compare against fixed expected words.
module tb_p1_byte_packer;

  logic        clk;
  logic        reset;
  logic        clear;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_word;
  logic        out_ready;
  logic [1:0]  byte_cnt;

  int errors;
  int checks;

  // Reference model state
  logic [7:0]  part[$];
  logic        m_valid;
  logic [31:0] m_word;
  logic [31:0] got_words[$];

  // Per-tick observations for the test tasks
  logic obs_ready;
  logic exp_ready;
  logic accepted;

  localparam int NUM_RANDOM = 10000;
  logic [7:0] sent_bytes[NUM_RANDOM];

  p1_byte_packer dut (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_word  (out_word),
    .out_ready (out_ready),
    .byte_cnt  (byte_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reset the model to the post-reset state
  task automatic reset_model();
    part.delete();
    m_valid = 1'b0;
    m_word  = 32'h0;
  endtask

  // Drive one cycle of inputs (called at posedge+1), advance the model, and
  // return at posedge+1 of the next cycle. No comparisons are made here.
  task automatic tick(input logic v, input logic [7:0] d, input logic ordy, input logic clr);
    logic [31:0] w;
    logic        load;
    logic        hs;
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    clear     = clr;
    #1;
    obs_ready = in_ready;
    exp_ready = (part.size() != 3) || !m_valid || ordy;
    hs        = m_valid && ordy;
    if (out_valid === 1'b1 && ordy) got_words.push_back(out_word);
    accepted = v && exp_ready && !clr;
    load = 1'b0;
    w    = 32'h0;
    if (clr) begin
      part.delete();
    end else if (accepted) begin
      part.push_back(d);
      if (part.size() == 4) begin
        w = {part[0], part[1], part[2], part[3]};
        part.delete();
        load = 1'b1;
      end
    end
    if (load) begin
      m_word  = w;
      m_valid = 1'b1;
    end else if (hs) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++;
    if (out_word !== 32'h0) begin errors++; $display("[TB] FAIL reset_out_word: got %h want 00000000", out_word); end
    checks++;
    if (byte_cnt !== 2'd0) begin errors++; $display("[TB] FAIL reset_byte_cnt: got %0d want 0", byte_cnt); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_basic();
    logic [7:0] bytes[4];
    bytes = '{8'h12, 8'h34, 8'h56, 8'h78};
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, bytes[i], 1'b1, 1'b0);
      checks++;
      if (byte_cnt !== 2'((i + 1) % 4)) begin
        errors++; $display("[TB] FAIL basic_byte_cnt: got %0d want %0d", byte_cnt, (i + 1) % 4);
      end
    end
    checks++;
    if (out_valid !== 1'b1 || out_word !== 32'h12345678) begin
      errors++; $display("[TB] FAIL basic_word: got v=%b %h want v=1 12345678", out_valid, out_word);
    end
    tick(1'b0, 8'h00, 1'b1, 1'b0);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_one_cycle: got out_valid=%b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    logic [7:0] first[4];
    logic [7:0] next[3];
    first = '{8'h12, 8'h34, 8'h56, 8'h78};
    next  = '{8'hAA, 8'hBB, 8'hCC};
    for (int i = 0; i < 4; i++) tick(1'b1, first[i], 1'b0, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_word !== 32'h12345678) begin
      errors++; $display("[TB] FAIL bp_first_word: got v=%b %h want v=1 12345678", out_valid, out_word);
    end
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, next[i], 1'b0, 1'b0);
      checks++;
      if (obs_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_ready_partial: got %b want 1", obs_ready); end
    end
    checks++;
    if (byte_cnt !== 2'd3 || out_word !== 32'h12345678) begin
      errors++; $display("[TB] FAIL bp_hold: got cnt=%0d %h want cnt=3 12345678", byte_cnt, out_word);
    end
    tick(1'b1, 8'hDD, 1'b0, 1'b0);
    checks++;
    if (obs_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_stall_ready: got %b want 0", obs_ready); end
    checks++;
    if (byte_cnt !== 2'd3 || out_word !== 32'h12345678 || out_valid !== 1'b1) begin
      errors++; $display("[TB] FAIL bp_stalled: got cnt=%0d v=%b %h want cnt=3 v=1 12345678", byte_cnt, out_valid, out_word);
    end
    tick(1'b1, 8'hDD, 1'b1, 1'b0);
    checks++;
    if (obs_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_release_ready: got %b want 1", obs_ready); end
    checks++;
    if (out_valid !== 1'b1 || out_word !== 32'hAABBCCDD || byte_cnt !== 2'd0) begin
      errors++; $display("[TB] FAIL bp_second_word: got v=%b %h cnt=%0d want v=1 AABBCCDD cnt=0", out_valid, out_word, byte_cnt);
    end
    tick(1'b0, 8'h00, 1'b1, 1'b0);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_drain: got out_valid=%b want 0", out_valid); end
  endtask

  task automatic test_clear();
    logic [7:0] bytes[4];
    bytes = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    tick(1'b1, 8'h11, 1'b1, 1'b0);
    tick(1'b1, 8'h22, 1'b1, 1'b0);
    tick(1'b1, 8'h33, 1'b1, 1'b1);
    checks++;
    if (byte_cnt !== 2'd0 || out_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL clear_cnt: got cnt=%0d v=%b want cnt=0 v=0", byte_cnt, out_valid);
    end
    for (int i = 0; i < 4; i++) tick(1'b1, bytes[i], 1'b1, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_word !== 32'hA0A1A2A3) begin
      errors++; $display("[TB] FAIL clear_next_word: got v=%b %h want v=1 A0A1A2A3", out_valid, out_word);
    end
    tick(1'b0, 8'h00, 1'b0, 1'b1);
    tick(1'b1, 8'h55, 1'b0, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || out_word !== 32'hA0A1A2A3 || byte_cnt !== 2'd0) begin
      errors++; $display("[TB] FAIL clear_keeps_output: got v=%b %h cnt=%0d want v=1 A0A1A2A3 cnt=0", out_valid, out_word, byte_cnt);
    end
    tick(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_async_reset();
    logic [7:0] bytes[4];
    bytes = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    for (int i = 1; i <= 6; i++) tick(1'b1, 8'(i), 1'b0, 1'b0);
    checks++;
    if (byte_cnt !== 2'd2 || out_valid !== 1'b1 || out_word !== 32'h01020304) begin
      errors++; $display("[TB] FAIL areset_setup: got cnt=%0d v=%b %h want cnt=2 v=1 01020304", byte_cnt, out_valid, out_word);
    end
    in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_word !== 32'h0 || byte_cnt !== 2'd0 || in_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL areset_immediate: got v=%b %h cnt=%0d rdy=%b want v=0 00000000 cnt=0 rdy=1",
                         out_valid, out_word, byte_cnt, in_ready);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    reset_model();
    for (int i = 0; i < 4; i++) tick(1'b1, bytes[i], 1'b1, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_word !== 32'hDEADBEEF) begin
      errors++; $display("[TB] FAIL areset_word: got v=%b %h want v=1 DEADBEEF", out_valid, out_word);
    end
    tick(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      tick(1'b1, 8'(i), 1'b1, 1'b0);
      checks++;
      if (obs_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ready: byte %0d got %b want 1", i, obs_ready); end
      if (i == 3) begin
        checks++;
        if (out_valid !== 1'b1 || out_word !== 32'h00010203) begin
          errors++; $display("[TB] FAIL b2b_word0: got v=%b %h want v=1 00010203", out_valid, out_word);
        end
      end
    end
    checks++;
    if (out_valid !== 1'b1 || out_word !== 32'h04050607) begin
      errors++; $display("[TB] FAIL b2b_word1: got v=%b %h want v=1 04050607", out_valid, out_word);
    end
    tick(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    int idx;
    int cycles;
    logic v;
    logic ordy;
    logic [31:0] exp_w;
    for (int i = 0; i < NUM_RANDOM; i++) sent_bytes[i] = 8'($urandom);
    got_words.delete();
    idx = 0;
    cycles = 0;
    while (idx < NUM_RANDOM && cycles < 60000) begin
      v    = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      tick(v, sent_bytes[idx], ordy, 1'b0);
      cycles++;
      if (accepted) idx++;
      checks++;
      if (obs_ready !== exp_ready) begin
        errors++; $display("[TB] FAIL rand_in_ready: cycle %0d got %b want %b", cycles, obs_ready, exp_ready);
      end
      checks++;
      if (out_valid !== m_valid || byte_cnt !== 2'(part.size()) || (m_valid && out_word !== m_word)) begin
        errors++; $display("[TB] FAIL rand_state: cycle %0d got v=%b %h cnt=%0d want v=%b %h cnt=%0d",
                           cycles, out_valid, out_word, byte_cnt, m_valid, m_word, part.size());
      end
    end
    checks++;
    if (idx < NUM_RANDOM) begin
      errors++; $display("[TB] FAIL rand_timeout: sent %0d bytes want %0d", idx, NUM_RANDOM);
    end
    cycles = 0;
    while (m_valid && cycles < 10) begin
      tick(1'b0, 8'h00, 1'b1, 1'b0);
      cycles++;
    end
    checks++;
    if (got_words.size() != NUM_RANDOM / 4) begin
      errors++; $display("[TB] FAIL rand_word_count: got %0d want %0d", got_words.size(), NUM_RANDOM / 4);
    end
    for (int i = 0; i < NUM_RANDOM / 4 && i < got_words.size(); i++) begin
      exp_w = {sent_bytes[4*i], sent_bytes[4*i+1], sent_bytes[4*i+2], sent_bytes[4*i+3]};
      checks++;
      if (got_words[i] !== exp_w) begin
        errors++; $display("[TB] FAIL rand_word: index %0d got %h want %h", i, got_words[i], exp_w);
      end
    end
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    reset     = 1'b1;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    reset_model();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    reset = 1'b0;
    test_basic();
    test_backpressure();
    test_clear();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
